// File: rtl/inst_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words,
// writes them to consecutive imem addresses and holds the CPU until ECALL or full.
module inst_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_WORDS  = 16384
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  bad_opcode
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [31:0]         ECALL   = 32'h0000_0073;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = MAX_WORDS[ADDR_WIDTH:0];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [1:0]            idx_q,   idx_d;
  logic [31:0]           word_q,  word_d;
  logic [ADDR_WIDTH:0]   cnt_q,   cnt_d;
  logic                  bad_q,   bad_d;
  logic [ADDR_WIDTH:0]   cnt_inc;

  // Opcodes the control decoder understands; funct fields are not inspected.
  function automatic logic op_known(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RECV;
          addr_d  = '0;
          idx_d   = 2'd0;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      S_RECV: begin
        // byte_ready is a pure state decode, so byte_valid alone marks a handshake here
        if (byte_valid) begin
          word_d[{idx_q, 3'b000} +: 8] = byte_in;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_inc;
        if (!op_known(word_q[6:0])) bad_d = 1'b1;
        if ((word_q == ECALL) || (cnt_inc == MAX_CNT)) state_d = S_DONE;
        else                                            state_d = S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= 2'd0;
      word_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  assign byte_ready = (state_q == S_RECV);
  assign imem_we    = (state_q == S_WRITE);
  assign cpu_hold   = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign word_count = cnt_q;
  assign bad_opcode = bad_q;

endmodule
